// File: rtl/dcache_mem_arbiter.sv
// Round-robin sharing of NUM_CHANNELS memory channels among dcache miss/writeback ports; grant and response relay each take 1 cycle.
// Backpressure: the consumer ready is held until the consumer drops its valid; requests beyond the free channels wait unclaimed.
module dcache_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                   mem_write_ready
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                                  state_q [NUM_CHANNELS];
    state_t                                  state_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][CW-1:0]         owner_q, owner_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  addr_q, addr_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  wdata_q, wdata_d;
    logic [NUM_CHANNELS-1:0]                 rd_vld_q, rd_vld_d;
    logic [NUM_CHANNELS-1:0]                 wr_vld_q, wr_vld_d;
    logic [NUM_CONSUMERS-1:0]                rd_rdy_q, rd_rdy_d;
    logic [NUM_CONSUMERS-1:0]                wr_rdy_q, wr_rdy_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_dat_q, rd_dat_d;
    logic [NUM_CONSUMERS-1:0]                claimed_q, claimed_d;
    logic [NUM_CONSUMERS-1:0]                pending, granted;
    logic [CW-1:0]                           rr_q, rr_d, pick;
    logic                                    found;
    int                                      idx;

    // A consumer still showing ready has not yet seen its release, so it cannot be regranted.
    assign pending = (consumer_read_valid | consumer_write_valid) & ~claimed_q & ~rd_rdy_q & ~wr_rdy_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_vld_d  = rd_vld_q;
        wr_vld_d  = wr_vld_q;
        rd_rdy_d  = rd_rdy_q;
        wr_rdy_d  = wr_rdy_q;
        rd_dat_d  = rd_dat_q;
        claimed_d = claimed_q;
        rr_d      = rr_q;
        granted   = '0;
        found     = 1'b0;
        pick      = '0;
        idx       = 0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                IDLE: begin
                    found = 1'b0;
                    pick  = '0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        idx = (int'(rr_q) + k) % NUM_CONSUMERS;
                        if (!found && pending[idx] && !granted[idx]) begin
                            found = 1'b1;
                            pick  = CW'(idx);
                        end
                    end
                    if (found) begin
                        granted[pick]   = 1'b1;
                        claimed_d[pick] = 1'b1;
                        owner_d[ch]     = pick;
                        rr_d            = CW'((int'(pick) + 1) % NUM_CONSUMERS);
                        // Eviction goes first; the read stays pending and is regranted after release.
                        if (consumer_write_valid[pick]) begin
                            addr_d[ch]   = consumer_write_address[pick];
                            wdata_d[ch]  = consumer_write_data[pick];
                            wr_vld_d[ch] = 1'b1;
                            state_d[ch]  = WRITE_WAITING;
                        end else begin
                            addr_d[ch]   = consumer_read_address[pick];
                            rd_vld_d[ch] = 1'b1;
                            state_d[ch]  = READ_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        rd_vld_d[ch] = 1'b0;
                        if (consumer_read_valid[owner_q[ch]]) begin
                            rd_rdy_d[owner_q[ch]] = 1'b1;
                            rd_dat_d[owner_q[ch]] = mem_read_data[ch];
                            state_d[ch]           = READ_RELAYING;
                        end else begin
                            claimed_d[owner_q[ch]] = 1'b0;
                            state_d[ch]            = IDLE;
                        end
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready[ch]) begin
                        wr_vld_d[ch] = 1'b0;
                        if (consumer_write_valid[owner_q[ch]]) begin
                            wr_rdy_d[owner_q[ch]] = 1'b1;
                            state_d[ch]           = WRITE_RELAYING;
                        end else begin
                            claimed_d[owner_q[ch]] = 1'b0;
                            state_d[ch]            = IDLE;
                        end
                    end
                end
                READ_RELAYING: begin
                    if (!consumer_read_valid[owner_q[ch]]) begin
                        rd_rdy_d[owner_q[ch]]  = 1'b0;
                        claimed_d[owner_q[ch]] = 1'b0;
                        state_d[ch]            = IDLE;
                    end
                end
                WRITE_RELAYING: begin
                    if (!consumer_write_valid[owner_q[ch]]) begin
                        wr_rdy_d[owner_q[ch]]  = 1'b0;
                        claimed_d[owner_q[ch]] = 1'b0;
                        state_d[ch]            = IDLE;
                    end
                end
                default: state_d[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
            end
            owner_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_vld_q  <= '0;
            wr_vld_q  <= '0;
            rd_rdy_q  <= '0;
            wr_rdy_q  <= '0;
            rd_dat_q  <= '0;
            claimed_q <= '0;
            rr_q      <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
            end
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_vld_q  <= rd_vld_d;
            wr_vld_q  <= wr_vld_d;
            rd_rdy_q  <= rd_rdy_d;
            wr_rdy_q  <= wr_rdy_d;
            rd_dat_q  <= rd_dat_d;
            claimed_q <= claimed_d;
            rr_q      <= rr_d;
        end
    end

    assign consumer_read_ready  = rd_rdy_q;
    assign consumer_read_data   = rd_dat_q;
    assign consumer_write_ready = wr_rdy_q;
    assign mem_read_valid       = rd_vld_q;
    assign mem_read_address     = addr_q;
    assign mem_write_valid      = wr_vld_q;
    assign mem_write_address    = addr_q;
    assign mem_write_data       = wdata_q;

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed bench: a two-channel and a one-channel arbiter share the consumer stimulus;
// each has a memory model answering two negedges after valid with data = address ^ 0xE5.
module tb_dcache_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst1 = 1'b1;
    logic            rst2 = 1'b1;
    logic            stall = 1'b0;
    logic [7:0]      crv = '0;
    logic [7:0]      cwv = '0;
    logic [7:0][7:0] cra = '0;
    logic [7:0][7:0] cwa = '0;
    logic [7:0][7:0] cwd = '0;

    logic [7:0]      rd_rdy2, wr_rdy2;
    logic [7:0][7:0] rd_dat2;
    logic [1:0]      m2_rvld, m2_wvld;
    logic [1:0]      m2_rrdy = '0;
    logic [1:0]      m2_wrdy = '0;
    logic [1:0][7:0] m2_raddr, m2_waddr, m2_wdat;
    logic [1:0][7:0] m2_rdat = '0;

    logic [7:0]      rd_rdy1, wr_rdy1;
    logic [7:0][7:0] rd_dat1;
    logic [0:0]      m1_rvld, m1_wvld;
    logic [0:0]      m1_rrdy = '0;
    logic [0:0]      m1_wrdy = '0;
    logic [0:0][7:0] m1_raddr, m1_waddr, m1_wdat;
    logic [0:0][7:0] m1_rdat = '0;

    int checks = 0;
    int errors = 0;
    int cnt2 [2] = '{0, 0};
    int cnt1 = 0;

    dcache_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(2)) u_dut2 (
        .clk(clk), .reset(rst2),
        .consumer_read_valid(crv), .consumer_read_address(cra),
        .consumer_read_ready(rd_rdy2), .consumer_read_data(rd_dat2),
        .consumer_write_valid(cwv), .consumer_write_address(cwa), .consumer_write_data(cwd),
        .consumer_write_ready(wr_rdy2),
        .mem_read_valid(m2_rvld), .mem_read_address(m2_raddr),
        .mem_read_ready(m2_rrdy), .mem_read_data(m2_rdat),
        .mem_write_valid(m2_wvld), .mem_write_address(m2_waddr), .mem_write_data(m2_wdat),
        .mem_write_ready(m2_wrdy)
    );

    dcache_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(1)) u_dut1 (
        .clk(clk), .reset(rst1),
        .consumer_read_valid(crv), .consumer_read_address(cra),
        .consumer_read_ready(rd_rdy1), .consumer_read_data(rd_dat1),
        .consumer_write_valid(cwv), .consumer_write_address(cwa), .consumer_write_data(cwd),
        .consumer_write_ready(wr_rdy1),
        .mem_read_valid(m1_rvld), .mem_read_address(m1_raddr),
        .mem_read_ready(m1_rrdy), .mem_read_data(m1_rdat),
        .mem_write_valid(m1_wvld), .mem_write_address(m1_waddr), .mem_write_data(m1_wdat),
        .mem_write_ready(m1_wrdy)
    );

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            m2_rrdy[c] = 1'b0;
            m2_wrdy[c] = 1'b0;
            if (!stall && (m2_rvld[c] || m2_wvld[c])) begin
                cnt2[c] = cnt2[c] + 1;
                if (cnt2[c] == 2) begin
                    cnt2[c]    = 0;
                    m2_rrdy[c] = m2_rvld[c];
                    m2_wrdy[c] = m2_wvld[c];
                    m2_rdat[c] = m2_raddr[c] ^ 8'hE5;
                end
            end else begin
                cnt2[c] = 0;
            end
        end
        m1_rrdy[0] = 1'b0;
        m1_wrdy[0] = 1'b0;
        if (!stall && (m1_rvld[0] || m1_wvld[0])) begin
            cnt1 = cnt1 + 1;
            if (cnt1 == 2) begin
                cnt1       = 0;
                m1_rrdy[0] = m1_rvld[0];
                m1_wrdy[0] = m1_wvld[0];
                m1_rdat[0] = m1_raddr[0] ^ 8'hE5;
            end
        end else begin
            cnt1 = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        step(2);
        chk("rst2_rvld", 32'(m2_rvld), 32'h0);
        chk("rst2_wvld", 32'(m2_wvld), 32'h0);
        chk("rst2_rrdy", 32'(rd_rdy2), 32'h0);
        chk("rst2_wrdy", 32'(wr_rdy2), 32'h0);
        chk("rst2_raddr", 32'(m2_raddr), 32'h0);
        rst2 = 1'b0;

        // saturation: four reads, two channels
        crv = 8'h0F;
        cra[0] = 8'h10; cra[1] = 8'h21; cra[2] = 8'h32; cra[3] = 8'h43;
        step(1);
        chk("sat_rvld_a", 32'(m2_rvld), 32'h3);
        chk("sat_addr_c0a", 32'(m2_raddr[0]), 32'h10);
        chk("sat_addr_c1a", 32'(m2_raddr[1]), 32'h21);
        step(2);
        chk("sat_rdy_a", 32'(rd_rdy2), 32'h03);
        chk("sat_dat0", 32'(rd_dat2[0]), 32'hF5);
        chk("sat_dat1", 32'(rd_dat2[1]), 32'hC4);
        chk("sat_rvld_off", 32'(m2_rvld), 32'h0);
        crv = 8'h0C;
        step(1);
        chk("sat_release", 32'(rd_rdy2), 32'h00);
        chk("sat_no_early", 32'(m2_rvld), 32'h0);
        step(1);
        chk("sat_rvld_b", 32'(m2_rvld), 32'h3);
        chk("sat_addr_c0b", 32'(m2_raddr[0]), 32'h32);
        chk("sat_addr_c1b", 32'(m2_raddr[1]), 32'h43);
        step(2);
        chk("sat_rdy_b", 32'(rd_rdy2), 32'h0C);
        chk("sat_dat2", 32'(rd_dat2[2]), 32'hD7);
        chk("sat_dat3", 32'(rd_dat2[3]), 32'hA6);
        crv = 8'h00;
        step(1);
        chk("sat_done", 32'(rd_rdy2), 32'h00);

        // single read, consumer 3 at 0x40; address change in flight is ignored
        crv[3] = 1'b1; cra[3] = 8'h40;
        step(1);
        chk("rd_rvld", 32'(m2_rvld), 32'h1);
        chk("rd_addr", 32'(m2_raddr[0]), 32'h40);
        cra[3] = 8'hFF;
        step(2);
        chk("rd_rdy", 32'(rd_rdy2), 32'h08);
        chk("rd_dat", 32'(rd_dat2[3]), 32'hA5);
        chk("rd_rvld_off", 32'(m2_rvld), 32'h0);
        step(1);
        chk("rd_rdy_held", 32'(rd_rdy2), 32'h08);
        crv[3] = 1'b0;
        step(1);
        chk("rd_release", 32'(rd_rdy2), 32'h00);

        // eviction, consumer 1
        cwv[1] = 1'b1; cwa[1] = 8'h12; cwd[1] = 8'h7E;
        step(1);
        chk("wr_wvld", 32'(m2_wvld), 32'h1);
        chk("wr_rvld", 32'(m2_rvld), 32'h0);
        chk("wr_addr", 32'(m2_waddr[0]), 32'h12);
        chk("wr_data", 32'(m2_wdat[0]), 32'h7E);
        step(2);
        chk("wr_rdy", 32'(wr_rdy2), 32'h02);
        chk("wr_wvld_off", 32'(m2_wvld), 32'h0);
        cwv[1] = 1'b0;
        step(1);
        chk("wr_release", 32'(wr_rdy2), 32'h00);

        // read and write together on consumer 4
        crv[4] = 1'b1; cra[4] = 8'h55;
        cwv[4] = 1'b1; cwa[4] = 8'h66; cwd[4] = 8'h99;
        step(1);
        chk("rw_wvld", 32'(m2_wvld), 32'h1);
        chk("rw_rvld", 32'(m2_rvld), 32'h0);
        chk("rw_waddr", 32'(m2_waddr[0]), 32'h66);
        chk("rw_wdata", 32'(m2_wdat[0]), 32'h99);
        step(2);
        chk("rw_wrdy", 32'(wr_rdy2), 32'h10);
        chk("rw_rrdy_early", 32'(rd_rdy2), 32'h00);
        cwv[4] = 1'b0;
        step(1);
        chk("rw_wrelease", 32'(wr_rdy2), 32'h00);
        chk("rw_no_read_yet", 32'(m2_rvld), 32'h0);
        step(1);
        chk("rw_rvld", 32'(m2_rvld), 32'h1);
        chk("rw_raddr", 32'(m2_raddr[0]), 32'h55);
        step(2);
        chk("rw_rrdy", 32'(rd_rdy2), 32'h10);
        chk("rw_rdat", 32'(rd_dat2[4]), 32'hB0);
        crv[4] = 1'b0;
        step(1);
        chk("rw_rrelease", 32'(rd_rdy2), 32'h00);

        // valid dropped while waiting: no ready pulse, channel back to idle
        crv[6] = 1'b1; cra[6] = 8'h70;
        step(1);
        chk("drop_rvld", 32'(m2_rvld), 32'h1);
        crv[6] = 1'b0;
        step(2);
        chk("drop_no_rdy", 32'(rd_rdy2), 32'h00);
        chk("drop_rvld_off", 32'(m2_rvld), 32'h0);
        crv[6] = 1'b1; cra[6] = 8'h71;
        step(1);
        chk("drop_regrant", 32'(m2_rvld), 32'h1);
        chk("drop_addr", 32'(m2_raddr[0]), 32'h71);
        step(2);
        chk("drop_rdy", 32'(rd_rdy2), 32'h40);
        chk("drop_dat", 32'(rd_dat2[6]), 32'h94);
        crv[6] = 1'b0;
        step(1);

        // contention on the single-channel arbiter: 0, 2, 5
        rst2 = 1'b1;
        rst1 = 1'b0;
        crv = 8'h25; cra[0] = 8'h01; cra[2] = 8'h02; cra[5] = 8'h05;
        step(1);
        chk("ct_g0_vld", 32'(m1_rvld), 32'h1);
        chk("ct_g0_addr", 32'(m1_raddr[0]), 32'h01);
        step(2);
        chk("ct_g0_rdy", 32'(rd_rdy1), 32'h01);
        chk("ct_g0_dat", 32'(rd_dat1[0]), 32'hE4);
        crv[0] = 1'b0;
        step(1);
        chk("ct_g0_rel", 32'(rd_rdy1), 32'h00);
        chk("ct_g0_gap", 32'(m1_rvld), 32'h0);
        step(1);
        chk("ct_g2_vld", 32'(m1_rvld), 32'h1);
        chk("ct_g2_addr", 32'(m1_raddr[0]), 32'h02);
        step(2);
        chk("ct_g2_rdy", 32'(rd_rdy1), 32'h04);
        crv[2] = 1'b0;
        step(1);
        chk("ct_g2_gap", 32'(m1_rvld), 32'h0);
        step(1);
        chk("ct_g5_addr", 32'(m1_raddr[0]), 32'h05);
        step(2);
        chk("ct_g5_rdy", 32'(rd_rdy1), 32'h20);
        crv[5] = 1'b0;
        step(1);
        chk("ct_g5_rel", 32'(rd_rdy1), 32'h00);

        // pointer sits at 6, so 7 beats 1; reset mid-wait then restarts the scan at 0
        stall = 1'b1;
        crv[1] = 1'b1; cra[1] = 8'h11;
        crv[7] = 1'b1; cra[7] = 8'h77;
        step(1);
        chk("rr6_vld", 32'(m1_rvld), 32'h1);
        chk("rr6_addr", 32'(m1_raddr[0]), 32'h77);
        step(1);
        chk("rst_wait_vld", 32'(m1_rvld), 32'h1);
        rst1 = 1'b1;
        #1;
        chk("rst_async_vld", 32'(m1_rvld), 32'h0);
        chk("rst_async_addr", 32'(m1_raddr[0]), 32'h00);
        chk("rst_async_rdy", 32'(rd_rdy1), 32'h00);
        step(1);
        rst1 = 1'b0;
        stall = 1'b0;
        step(1);
        chk("rst_regrant_vld", 32'(m1_rvld), 32'h1);
        chk("rst_regrant_addr", 32'(m1_raddr[0]), 32'h11);
        step(2);
        chk("rst_regrant_rdy", 32'(rd_rdy1), 32'h02);
        chk("rst_regrant_dat", 32'(rd_dat1[1]), 32'hF4);
        crv = 8'h00;
        step(1);
        chk("rst_final_rel", 32'(rd_rdy1), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_mem_arbiter.md
Name: dcache_mem_arbiter

Overview:
- Shares NUM_CHANNELS memory channels among the per-consumer miss/writeback ports of the data cache (its controller_* read and write interfaces).
- Sits between the dcache and the global memory controller.
- Each channel owns at most one consumer transaction at a time: grant, forward to memory, return the response, then release once the consumer drops valid.
- Consumer selection is round-robin so no cache port starves.

Parameters:
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 8, number of dcache miss ports
- NUM_CHANNELS, 2, number of memory channels (1 <= NUM_CHANNELS <= NUM_CONSUMERS)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset; one clock domain only
- consumer_read_valid  input  [NUM_CONSUMERS]  read request per consumer
- consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  read address
- consumer_read_ready  output  [NUM_CONSUMERS]  read data valid, held until valid drops
- consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  returned read data
- consumer_write_valid  input  [NUM_CONSUMERS]  write (eviction) request
- consumer_write_address  input  [NUM_CONSUMERS][ADDR_BITS]  write address
- consumer_write_data  input  [NUM_CONSUMERS][DATA_BITS]  write data
- consumer_write_ready  output  [NUM_CONSUMERS]  write done, held until valid drops
- mem_read_valid  output  [NUM_CHANNELS]  memory read request
- mem_read_address  output  [NUM_CHANNELS][ADDR_BITS]  memory read address
- mem_read_ready  input  [NUM_CHANNELS]  memory read complete
- mem_read_data  input  [NUM_CHANNELS][DATA_BITS]  memory read data
- mem_write_valid  output  [NUM_CHANNELS]  memory write request
- mem_write_address  output  [NUM_CHANNELS][ADDR_BITS]  memory write address
- mem_write_data  output  [NUM_CHANNELS][DATA_BITS]  memory write data
- mem_write_ready  input  [NUM_CHANNELS]  memory write complete

Behaviour:

Reset (asynchronous, takes effect immediately):
- All outputs 0, all channels IDLE, rr_ptr=0, all consumer claims cleared.
- Reset mid-transaction abandons it; memory-side valids drop without waiting for ready.

Per-channel FSM, states IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING:
- IDLE: select a pending unclaimed consumer (see arbitration). At the next edge, claim it and register its address (and data for writes).
  - Write request: assert mem_write_valid, go to WRITE_WAITING.
  - Otherwise read: assert mem_read_valid, go to READ_WAITING.
- READ_WAITING, on mem_read_ready: drop mem_read_valid, set consumer_read_ready=1, consumer_read_data=mem_read_data, go to READ_RELAYING.
- WRITE_WAITING, on mem_write_ready: drop mem_write_valid, set consumer_write_ready=1, go to WRITE_RELAYING.
- *_RELAYING: once the consumer's corresponding valid is seen low, clear that ready, release the claim, go to IDLE.

Arbitration:
- Pending = (read_valid | write_valid) and not claimed and ready low.
- Channels evaluated in ascending index within a cycle. Each IDLE channel takes the first pending consumer scanning from rr_ptr upward, modulo NUM_CONSUMERS.
- A consumer is granted to at most one channel per cycle.
- After any grant, rr_ptr = (highest-scanned granted consumer + 1) mod NUM_CONSUMERS; no grant leaves rr_ptr unchanged.
- Write has priority over read for the same consumer. Its read is served in a later grant after the write relay completes.

Latency:
- Request visible at edge N gives mem valid high after edge N+1 (1 cycle).
- mem ready at edge M gives consumer ready high after edge M+1.
- Consumer valid low at edge K gives ready low and channel IDLE after edge K+1; the channel can regrant at edge K+2.

Boundary conditions:
- More pending consumers than channels: the extras wait, never dropped.
- Consumer valid dropped while WAITING: the memory transaction still completes, the ready pulse is skipped, and the channel returns to IDLE directly.
- Addresses and data are latched at grant; input changes while in flight are ignored.
- Never drive mem_read_valid and mem_write_valid together on one channel.

Test Plan:
- Single read: NUM_CHANNELS=2, consumer 3 reads addr 0x40. Memory answers ready with data 0xA5 two cycles after valid. Expect mem_read_valid[0]=1 with addr 0x40, then consumer_read_ready[3]=1 with data 0xA5 held until valid drops, then ready=0 one cycle later.
- Eviction: consumer 1 issues write addr 0x12 data 0x7E. Expect mem_write_valid[0]=1 with addr 0x12 and data 0x7E, then consumer_write_ready[1]=1, then release.
- Contention: NUM_CHANNELS=1, consumers 0, 2, 5 request in the same cycle. Expect grant order 0, 2, 5; each starts only after the previous relay releases, and rr_ptr ends at 6.
- Channel saturation: NUM_CHANNELS=2, 4 simultaneous reads. Expect consumers 0 and 1 on channels 0 and 1 in the same cycle; 2 and 3 granted only after releases.
- Read and write on one consumer: consumer 4 asserts both. Expect the write (mem_write_valid) first, then the read granted after the write relay completes.
- Reset mid-op: assert reset while a channel is in READ_WAITING. Expect immediate zero outputs; after deassert, the same request is regranted starting at rr_ptr=0.
